// File: rtl/fft_peak_reader.sv
// Sweeps the FFT magnitude RAM once per frame and reports the two largest local-maximum bins.
// Latency: start edge to done pulse is (N_BINS-DC_SKIP) + RD_LAT + 3 cycles.
// No backpressure: one bin is read per cycle; start edges during a sweep are ignored, abort returns to idle.
module fft_peak_reader #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int N_BINS  = 2048,
  parameter int DC_SKIP = 4,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] thresh,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [ADDR_W-1:0] pk1_bin,
  output logic [DATA_W-1:0] pk1_mag,
  output logic [ADDR_W-1:0] pk2_bin,
  output logic [DATA_W-1:0] pk2_mag
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(DC_SKIP);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_BINS - 1);
  localparam logic [1:0]        DRAIN_END  = 2'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  // Control state
  state_t              state_q, state_d;
  logic                start_prev_q, start_prev_d;
  logic [DATA_W-1:0]   thresh_q, thresh_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]          drain_cnt_q, drain_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rv_q, rv_d;
  logic [ADDR_W-1:0]   pk1_bin_q, pk1_bin_d, pk2_bin_q, pk2_bin_d;
  logic [DATA_W-1:0]   pk1_mag_q, pk1_mag_d, pk2_mag_q, pk2_mag_d;
  logic                start_edge;
  logic                clr_work;
  logic                flush;

  // Read-latency delay line tagging each returning word with its bin
  logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
  logic [ADDR_W-1:0]   addr_pipe_q [RD_LAT];
  logic [ADDR_W-1:0]   addr_pipe_d [RD_LAT];
  logic                tag_vld;
  logic [ADDR_W-1:0]   tag_addr;

  // Peak window: a is the oldest sample, b the candidate, the incoming word is c
  logic                win_a_vld_q, win_a_vld_d, win_b_vld_q, win_b_vld_d;
  logic [DATA_W-1:0]   win_a_mag_q, win_a_mag_d, win_b_mag_q, win_b_mag_d;
  logic [ADDR_W-1:0]   win_b_bin_q, win_b_bin_d;
  logic                shift;
  logic [DATA_W-1:0]   c_mag;
  logic                is_peak;

  // Working top-2 list, published on DONE
  logic [ADDR_W-1:0]   w1_bin_q, w1_bin_d, w2_bin_q, w2_bin_d;
  logic [DATA_W-1:0]   w1_mag_q, w1_mag_d, w2_mag_q, w2_mag_d;

  assign start_edge = start & ~start_prev_q;
  assign tag_vld    = vld_pipe_q[RD_LAT-1];
  assign tag_addr   = addr_pipe_q[RD_LAT-1];

  // Sweep FSM: next state, address generation and result publishing
  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    thresh_d     = thresh_q;
    rd_addr_d    = rd_addr_q;
    drain_cnt_d  = drain_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rv_d         = rv_q;
    pk1_bin_d    = pk1_bin_q;
    pk1_mag_d    = pk1_mag_q;
    pk2_bin_d    = pk2_bin_q;
    pk2_mag_d    = pk2_mag_q;
    clr_work     = 1'b0;
    flush        = 1'b0;
    if (abort) begin
      // Abort dominates a coincident start edge; published peaks are kept.
      state_d = S_IDLE;
      busy_d  = 1'b0;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_d   = S_READ;
            thresh_d  = thresh;
            rd_addr_d = FIRST_ADDR;
            busy_d    = 1'b1;
            rv_d      = 1'b0;
            clr_work  = 1'b1;
          end
        end
        S_READ: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_d     = S_DRAIN;
            drain_cnt_d = 2'd0;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // Last drain cycle pushes a zero into the window so the final bin is tested.
          if (drain_cnt_q == DRAIN_END) begin
            flush   = 1'b1;
            state_d = S_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + 2'd1;
          end
        end
        S_DONE: begin
          pk1_bin_d = w1_bin_q;
          pk1_mag_d = w1_mag_q;
          pk2_bin_d = w2_bin_q;
          pk2_mag_d = w2_mag_q;
          done_d    = 1'b1;
          rv_d      = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: tag alignment, 3-sample peak test and top-2 insertion
  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    addr_pipe_d    = addr_pipe_q;
    vld_pipe_d[0]  = (state_q == S_READ) && !abort;
    addr_pipe_d[0] = rd_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1] && !abort;
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end

    shift   = tag_vld | flush;
    c_mag   = tag_vld ? rd_data : '0;
    is_peak = shift && win_a_vld_q && win_b_vld_q &&
              (win_b_mag_q > win_a_mag_q) && (win_b_mag_q >= c_mag) &&
              (win_b_mag_q >= thresh_q);

    win_a_vld_d = win_a_vld_q;
    win_a_mag_d = win_a_mag_q;
    win_b_vld_d = win_b_vld_q;
    win_b_mag_d = win_b_mag_q;
    win_b_bin_d = win_b_bin_q;
    w1_bin_d    = w1_bin_q;
    w1_mag_d    = w1_mag_q;
    w2_bin_d    = w2_bin_q;
    w2_mag_d    = w2_mag_q;

    if (shift) begin
      win_a_vld_d = win_b_vld_q;
      win_a_mag_d = win_b_mag_q;
      win_b_vld_d = tag_vld;
      win_b_mag_d = c_mag;
      win_b_bin_d = tag_addr;
    end

    // Candidates arrive in ascending bin order, so strict compares favour the lower bin on ties.
    if (is_peak) begin
      if (win_b_mag_q > w1_mag_q) begin
        w2_bin_d = w1_bin_q;
        w2_mag_d = w1_mag_q;
        w1_bin_d = win_b_bin_q;
        w1_mag_d = win_b_mag_q;
      end else if (win_b_mag_q > w2_mag_q) begin
        w2_bin_d = win_b_bin_q;
        w2_mag_d = win_b_mag_q;
      end
    end

    if (clr_work || abort) begin
      win_a_vld_d = 1'b0;
      win_b_vld_d = 1'b0;
    end
    if (clr_work) begin
      w1_bin_d = '0;
      w1_mag_d = '0;
      w2_bin_d = '0;
      w2_mag_d = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      thresh_q     <= '0;
      rd_addr_q    <= '0;
      drain_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rv_q         <= 1'b0;
      pk1_bin_q    <= '0;
      pk1_mag_q    <= '0;
      pk2_bin_q    <= '0;
      pk2_mag_q    <= '0;
      vld_pipe_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_pipe_q[i] <= '0;
      win_a_vld_q  <= 1'b0;
      win_a_mag_q  <= '0;
      win_b_vld_q  <= 1'b0;
      win_b_mag_q  <= '0;
      win_b_bin_q  <= '0;
      w1_bin_q     <= '0;
      w1_mag_q     <= '0;
      w2_bin_q     <= '0;
      w2_mag_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      thresh_q     <= thresh_d;
      rd_addr_q    <= rd_addr_d;
      drain_cnt_q  <= drain_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rv_q         <= rv_d;
      pk1_bin_q    <= pk1_bin_d;
      pk1_mag_q    <= pk1_mag_d;
      pk2_bin_q    <= pk2_bin_d;
      pk2_mag_q    <= pk2_mag_d;
      vld_pipe_q   <= vld_pipe_d;
      addr_pipe_q  <= addr_pipe_d;
      win_a_vld_q  <= win_a_vld_d;
      win_a_mag_q  <= win_a_mag_d;
      win_b_vld_q  <= win_b_vld_d;
      win_b_mag_q  <= win_b_mag_d;
      win_b_bin_q  <= win_b_bin_d;
      w1_bin_q     <= w1_bin_d;
      w1_mag_q     <= w1_mag_d;
      w2_bin_q     <= w2_bin_d;
      w2_mag_q     <= w2_mag_d;
    end
  end

  assign rd_addr      = rd_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = rv_q;
  assign pk1_bin      = pk1_bin_q;
  assign pk1_mag      = pk1_mag_q;
  assign pk2_bin      = pk2_bin_q;
  assign pk2_mag      = pk2_mag_q;

endmodule

// File: tb/tb_fft_peak_reader.sv
// Directed bench for fft_peak_reader: one instance with RD_LAT=1 and one with RD_LAT=2 share a RAM image.
// Expected latency is (2048-4)+RD_LAT+3 edges from the edge that samples the start rise.
// Both instances see identical start/abort/thresh stimulus.
module tb_fft_peak_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] thresh = '0;

  logic [11:0] rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2, rd_data2_s;
  logic        busy1, busy2, done1, done2, rv1, rv2;
  logic [11:0] pk1_bin1, pk2_bin1, pk1_bin2, pk2_bin2;
  logic [15:0] pk1_mag1, pk2_mag1, pk1_mag2, pk2_mag2;

  logic [15:0] mem [4096];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int t0 = 0;
  int dn1 = 0, dn2 = 0;
  int d1_cyc = 0, d2_cyc = 0;
  int min1 = 4096, min2 = 4096;
  logic fb_busy, fb_rv;
  logic [11:0] fb_pk1;

  always #5 clk = ~clk;

  fft_peak_reader #(.ADDR_W(12), .DATA_W(16), .N_BINS(2048), .DC_SKIP(4), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .thresh(thresh),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1), .done(done1), .result_valid(rv1),
    .pk1_bin(pk1_bin1), .pk1_mag(pk1_mag1), .pk2_bin(pk2_bin1), .pk2_mag(pk2_mag1)
  );

  fft_peak_reader #(.ADDR_W(12), .DATA_W(16), .N_BINS(2048), .DC_SKIP(4), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .thresh(thresh),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .done(done2), .result_valid(rv2),
    .pk1_bin(pk1_bin2), .pk1_mag(pk1_mag2), .pk2_bin(pk2_bin2), .pk2_mag(pk2_mag2)
  );

  // RAM read ports: one registered stage for instance 1, two for instance 2
  always @(posedge clk) begin
    rd_data1   <= mem[rd_addr1];
    rd_data2_s <= mem[rd_addr2];
    rd_data2   <= rd_data2_s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done1) begin dn1++; d1_cyc = cyc; end
    if (done2) begin dn2++; d2_cyc = cyc; end
    if (busy1 && int'(rd_addr1) < min1) min1 = int'(rd_addr1);
    if (busy2 && int'(rd_addr2) < min2) min2 = int'(rd_addr2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 4096; i++) mem[i] = v;
  endtask

  task automatic clr_counts();
    dn1 = 0; dn2 = 0; d1_cyc = 0; d2_cyc = 0; min1 = 4096; min2 = 4096;
  endtask

  // Raise start, run until both instances pulse done (bounded), then drop start.
  task automatic sweep();
    clr_counts();
    start = 1'b1;
    t0 = cyc;
    tick();
    fb_busy = busy1;
    fb_rv   = rv1;
    fb_pk1  = pk1_bin1;
    for (int i = 0; i < 2200 && !(dn1 > 0 && dn2 > 0); i++) tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    ticks(2);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rv", rv1, 0);
    chk("rst_rd_addr", rd_addr1, 0);
    chk("rst_pk1_bin", pk1_bin1, 0);
    chk("rst_pk2_mag", pk2_mag2, 0);
    rst_n = 1'b1;
    ticks(2);

    // 1: flat spectrum, no peaks
    fill(16'd100);
    thresh = 16'd50;
    sweep();
    chk("s1_busy_rise", fb_busy, 1);
    chk("s1_lat1", d1_cyc - t0, 2048);
    chk("s1_lat2", d2_cyc - t0, 2049);
    chk("s1_done_cnt", dn1, 1);
    chk("s1_rv", rv1, 1);
    chk("s1_busy_end", busy1, 0);
    chk("s1_pk1_bin", pk1_bin1, 0);
    chk("s1_pk1_mag", pk1_mag1, 0);
    chk("s1_pk2_bin", pk2_bin1, 0);
    chk("s1_pk2_mag", pk2_mag1, 0);

    // 2: two distinct peaks, both latencies
    fill(16'd10);
    mem[205] = 16'd9000;
    mem[410] = 16'd4000;
    thresh = 16'd500;
    sweep();
    chk("s2_rv_cleared", fb_rv, 0);
    chk("s2_pk1_bin", pk1_bin1, 205);
    chk("s2_pk1_mag", pk1_mag1, 9000);
    chk("s2_pk2_bin", pk2_bin1, 410);
    chk("s2_pk2_mag", pk2_mag1, 4000);
    chk("s7_pk1_bin", pk1_bin2, 205);
    chk("s7_pk1_mag", pk1_mag2, 9000);
    chk("s7_pk2_bin", pk2_bin2, 410);
    chk("s7_pk2_mag", pk2_mag2, 4000);
    chk("s7_lat", d2_cyc - t0, 2049);
    chk("s7_done_cnt", dn2, 1);

    // 3: equal peaks rank by bin; plateau gives one peak
    fill(16'd10);
    mem[300] = 16'd5000;
    mem[600] = 16'd5000;
    mem[700] = 16'd3000;
    mem[701] = 16'd3000;
    sweep();
    chk("s3_pk_hold", fb_pk1, 205);
    chk("s3_pk1_bin", pk1_bin1, 300);
    chk("s3_pk2_bin", pk2_bin1, 600);
    chk("s3_pk2_mag", pk2_mag1, 5000);
    mem[300] = 16'd10;
    mem[600] = 16'd10;
    sweep();
    chk("s3_plat_pk1_bin", pk1_bin1, 700);
    chk("s3_plat_pk1_mag", pk1_mag1, 3000);
    chk("s3_plat_pk2_bin", pk2_bin1, 0);
    chk("s3_plat_pk2_mag", pk2_mag1, 0);

    // 4: DC bins skipped, first swept bin never a peak, last bin tested
    fill(16'd10);
    mem[2]    = 16'd60000;
    mem[4]    = 16'd8000;
    mem[2047] = 16'd7000;
    sweep();
    chk("s4_pk1_bin", pk1_bin1, 2047);
    chk("s4_pk1_mag", pk1_mag1, 7000);
    chk("s4_pk2_bin", pk2_bin1, 0);
    chk("s4_min_addr", min1, 4);
    chk("s4_pk1_bin_l2", pk1_bin2, 2047);
    chk("s4_min_addr_l2", min2, 4);

    // 5: abort mid-sweep
    clr_counts();
    start = 1'b1;
    ticks(1000);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5_busy", busy1, 0);
    chk("s5_rv", rv1, 0);
    chk("s5_busy_l2", busy2, 0);
    chk("s5_pk_kept", pk1_bin1, 2047);
    ticks(1500);
    chk("s5_no_done", dn1, 0);
    chk("s5_no_done_l2", dn2, 0);
    fill(16'd10);
    mem[205] = 16'd9000;
    mem[410] = 16'd4000;
    sweep();
    chk("s5_lat", d1_cyc - t0, 2048);
    chk("s5_pk1_bin", pk1_bin1, 205);
    chk("s5_pk2_bin", pk2_bin1, 410);
    chk("s5_rv", rv1, 1);

    // 6: held start gives one sweep; a second edge during READ is ignored
    clr_counts();
    start = 1'b1;
    ticks(5000);
    chk("s6_held_cnt", dn1, 1);
    chk("s6_held_cnt_l2", dn2, 1);
    start = 1'b0;
    tick();
    clr_counts();
    start = 1'b1;
    ticks(500);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("s6_busy_mid", busy1, 1);
    ticks(3000);
    start = 1'b0;
    chk("s6_reedge_cnt", dn1, 1);
    chk("s6_pk1_mag", pk1_mag1, 9000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
